pixel_kernel_seq: RTL and testbench
===================================

# pixel_kernel_seq

Upstream sequencer for the pixel FSM. It sweeps a kernel of `NPIX` pixels by issuing one `pxl_start` pulse per pixel and waiting for that pixel's `pxl_done` before moving on. It also implements the local and adjacent timers that the pixel FSM enables, returning a timer-max indication to it for each. It sits between the Wishbone/LA control layer and the pixel FSM in the user project area, and reports kernel completion and timeout errors upward.

## Interface

Parameters:
- `NPIX`, default 9: pixels per kernel, allowed range 1..16.
- `CW`, default 10: timer compare width, matching `loc_max_clk`/`adj_max_clk`.
- `TO_CYCLES`, default 4095: watchdog limit in WAIT state, 16-bit.

Ports:
- `clk` input 1: single clock, all logic on its rising edge.
- `reset_n` input 1: reset is asynchronous and active-low.
- `start_i` input 1: kernel start request, level-sampled in IDLE.
- `abort_i` input 1: synchronous abort, returns the block to IDLE.
- `loc_max_clk` input CW: local timer terminal count.
- `adj_max_clk` input CW: adjacent timer terminal count.
- `loc_timer_en` input 1: local timer enable from the pixel FSM.
- `adj_timer_en` input 1: adjacent timer enable from the pixel FSM.
- `pxl_done_i` input 1: pixel-done from the pixel FSM.
- `pxl_start_o` output 1: one-cycle start pulse to the pixel FSM.
- `loc_timer_m_o` output 1: local timer at max, to the pixel FSM.
- `adj_timer_m_o` output 1: adjacent timer at max, to the pixel FSM.
- `pxl_idx_o` output 4: index of the pixel currently being processed.
- `busy_o` output 1: high whenever the state is not IDLE.
- `kernel_done_o` output 1: one-cycle pulse when all NPIX pixels have completed.
- `err_o` output 1: sticky watchdog-timeout flag.

## Operation

- Reset values: all outputs are 0, state is IDLE, the index and both timer counters are 0.
- Timers: there are two identical, independent CW-bit counters.
  - While `*_en` is 0, the counter is cleared to 0.
  - While `*_en` is 1, the counter increments each cycle and saturates at `*_max_clk`.
  - `*_m_o` = `*_en` AND (count == `*_max_clk`). This is combinational from the registered count.
  - If `*_max_clk` = 0, `*_m_o` is high in the first enabled cycle.
  - If `*_max_clk` changes below the current count, the counter holds and `*_m_o` stays low until `*_en` drops.
  - The timers run regardless of FSM state and are not affected by `abort_i`.
- FSM states: IDLE, START, WAIT, GAP, DONE.
  - IDLE: when `start_i` is 1, go to START, set idx to 0, and clear `err_o`.
  - START: `pxl_start_o` = 1 for exactly this cycle. Next state is WAIT, and the watchdog is cleared.
  - WAIT: the watchdog increments each cycle.
    - On `pxl_done_i` = 1 with idx == NPIX-1, go to DONE.
    - On `pxl_done_i` = 1 with any other idx, increment idx and go to GAP.
    - Else, if watchdog == TO_CYCLES, set `err_o` to 1 and go to IDLE.
  - GAP: one idle cycle that guarantees `pxl_start_o` is low between pulses, then go to START.
  - DONE: `kernel_done_o` = 1 for this cycle, then go to IDLE.
- `pxl_idx_o` always reflects the registered idx.
- `busy_o` = (state != IDLE).
- Priorities:
  - `abort_i` beats everything. From any state it gives IDLE next cycle with no `kernel_done_o`; idx and `err_o` are held.
  - `pxl_done_i` beats watchdog timeout when both occur on the same edge.
- Ignored inputs:
  - `start_i` is ignored outside IDLE.
  - `pxl_done_i` is ignored outside WAIT.
- Asserting `reset_n` mid-kernel immediately forces the reset values above.

## Timing

- `start_i` sampled high at edge k:
  - `busy_o` rises at k.
  - `pxl_start_o` is high from k to k+1.
- `pxl_done_i` sampled at edge m, for a non-last pixel:
  - idx increments at m.
  - GAP occupies m to m+1.
  - The next `pxl_start_o` is high from m+1 to m+2.
  - Minimum pixel period is therefore 3 cycles plus the pixel FSM's latency.
- Last pixel, `pxl_done_i` at edge m: `kernel_done_o` is high from m to m+1, and `busy_o` falls at m+1.
- Timeout: `err_o` rises on the edge where the watchdog equals TO_CYCLES, i.e. TO_CYCLES+1 edges after entering WAIT.
- Timer `*_m_o` is valid in the same cycle as the count; there is no added pipeline stage.

## Test plan

- Reset and basic sweep, NPIX=9:
  - Stimulus: pulse `start_i`; the pixel-FSM model answers each `pxl_start_o` with `pxl_done_i` after 5 cycles.
  - Required: exactly 9 `pxl_start_o` pulses, each 1 cycle wide, 8 cycles apart; `pxl_idx_o` runs 0..8; one `kernel_done_o` pulse; `busy_o` low afterwards.
- Timers:
  - Stimulus: `loc_max_clk`=3 with `loc_timer_en` high for 6 cycles; `adj_max_clk`=0 with `adj_timer_en` high for 2 cycles.
  - Required: `loc_timer_m_o` is high in cycles 4–6 of enable; `adj_timer_m_o` is high in both enabled cycles; both drop the cycle their enable drops.
- Watchdog:
  - Stimulus: TO_CYCLES=20, and `pxl_done_i` is never returned.
  - Required: `err_o` rises 21 edges after WAIT entry; state returns to IDLE; no `kernel_done_o`.
  - Then: a new `start_i`.
  - Required: `err_o` clears.
- Same-edge events:
  - Stimulus: `pxl_done_i` on the same edge as the timeout.
  - Required: treated as done, `err_o` stays 0.
  - Stimulus: `abort_i` on the same edge as the last `pxl_done_i`.
  - Required: IDLE, no `kernel_done_o`.
- Protocol robustness:
  - Stimulus: `start_i` held high through an entire kernel.
  - Required: a second kernel starts the cycle after DONE.
  - Stimulus: `pxl_done_i` asserted during START or GAP.
  - Required: ignored, idx unchanged.
- Async reset mid-operation:
  - Stimulus: drop `reset_n` while in WAIT with idx=4.
  - Required: all outputs go to 0 immediately, without waiting for a clock edge.
  - Then: release `reset_n` and pulse `start_i`.
  - Required: the sweep restarts at idx 0.

Source files
------------

// File: rtl/pixel_kernel_seq.sv
`default_nettype none
// ============================================================================
// Module      : pixel_kernel_seq
// Description : Kernel sequencer for the pixel FSM. Issues one start pulse per
//               pixel, waits for each pixel-done, guards each wait with a
//               watchdog, and provides the local/adjacent saturating timers
//               whose terminal-count flags feed back to the pixel FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_kernel_seq #(
    parameter int NPIX      = 9,
    parameter int CW        = 10,
    parameter int TO_CYCLES = 4095
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [CW-1:0] loc_max_clk,
    input  logic [CW-1:0] adj_max_clk,
    input  logic          loc_timer_en,
    input  logic          adj_timer_en,
    input  logic          pxl_done_i,
    output logic          pxl_start_o,
    output logic          loc_timer_m_o,
    output logic          adj_timer_m_o,
    output logic [3:0]    pxl_idx_o,
    output logic          busy_o,
    output logic          kernel_done_o,
    output logic          err_o
);

    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_start = 3'd1;
    localparam logic [2:0]  c_st_wait  = 3'd2;
    localparam logic [2:0]  c_st_gap   = 3'd3;
    localparam logic [2:0]  c_st_done  = 3'd4;

    localparam logic [3:0]  c_last_idx = 4'(NPIX - 1);
    localparam logic [15:0] c_to_limit = 16'(TO_CYCLES);

    // ------------------------------------------------------------------------
    // Local / adjacent timers: identical saturating counters. Index 0 is the
    // local timer, index 1 the adjacent timer.
    // ------------------------------------------------------------------------
    logic [1:0]    w_tmr_en;
    logic [CW-1:0] w_tmr_max [2];
    logic [1:0]    w_tmr_m;

    assign w_tmr_en     = {adj_timer_en, loc_timer_en};
    assign w_tmr_max[0] = loc_max_clk;
    assign w_tmr_max[1] = adj_max_clk;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_timer
            logic [CW-1:0] r_cnt;

            // Clear while disabled; count up to the terminal value and hold
            // there (or hold wherever it is if the terminal was lowered below it).
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (!w_tmr_en[g]) begin
                    r_cnt <= '0;
                end else if (r_cnt < w_tmr_max[g]) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_tmr_m[g] = w_tmr_en[g] && (r_cnt == w_tmr_max[g]);
        end
    endgenerate

    assign loc_timer_m_o = w_tmr_m[0];
    assign adj_timer_m_o = w_tmr_m[1];

    // ------------------------------------------------------------------------
    // Kernel sweep FSM and its datapath (pixel index, watchdog, error flag)
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [3:0]  r_idx;
    logic [15:0] r_wd;
    logic        r_err;
    logic        w_idx_last;
    logic        w_wd_expired;

    assign w_idx_last   = (r_idx == c_last_idx);
    assign w_wd_expired = (r_wd == c_to_limit);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every transition, and a pixel-done
    // wins over a coincident watchdog expiry.
    always_comb begin
        w_next_state = r_state;
        if (abort_i) begin
            w_next_state = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (start_i) w_next_state = c_st_start;
                c_st_start: w_next_state = c_st_wait;
                c_st_wait: begin
                    if (pxl_done_i) begin
                        w_next_state = w_idx_last ? c_st_done : c_st_gap;
                    end else if (w_wd_expired) begin
                        w_next_state = c_st_idle;
                    end
                end
                c_st_gap:   w_next_state = c_st_start;
                c_st_done:  w_next_state = c_st_idle;
                default:    w_next_state = c_st_idle;
            endcase
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        pxl_start_o   = (r_state == c_st_start);
        kernel_done_o = (r_state == c_st_done);
        busy_o        = (r_state != c_st_idle);
    end

    // Pixel index, watchdog and sticky error; all held on abort
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            r_wd  <= '0;
            r_err <= 1'b0;
        end else if (!abort_i) begin
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        r_idx <= '0;
                        r_err <= 1'b0;
                    end
                end
                c_st_start: begin
                    r_wd <= '0;
                end
                c_st_wait: begin
                    if (pxl_done_i) begin
                        if (!w_idx_last) begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end else if (w_wd_expired) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pxl_idx_o = r_idx;
    assign err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_kernel_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_kernel_seq
// Description : Self-checking bench for pixel_kernel_seq with a cycle-level
//               behavioural reference, a pixel-FSM responder, directed
//               scenarios and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_kernel_seq;

    localparam int NPIX = 9;
    localparam int CW   = 10;
    localparam int TO   = 20;

    localparam int PH_IDLE  = 0;
    localparam int PH_START = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_GAP   = 3;
    localparam int PH_DONE  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [CW-1:0] loc_max_clk = '0;
    logic [CW-1:0] adj_max_clk = '0;
    logic          loc_timer_en = 1'b0;
    logic          adj_timer_en = 1'b0;
    logic          pxl_done_i;
    logic          pxl_start_o;
    logic          loc_timer_m_o;
    logic          adj_timer_m_o;
    logic [3:0]    pxl_idx_o;
    logic          busy_o;
    logic          kernel_done_o;
    logic          err_o;

    logic resp_done  = 1'b0;
    logic force_done = 1'b0;
    logic resp_en    = 1'b0;
    int   resp_delay = 6;
    int   resp_cnt   = 0;

    assign pxl_done_i = resp_done | force_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int   start_cyc_q[$];
    int   start_idx_q[$];
    int   mon_wide = 0;
    int   mon_done_cnt = 0;
    logic mon_prev_start = 1'b0;

    int m_ph = PH_IDLE, m_idx = 0, m_wd = 0, m_err = 0, m_loc = 0, m_adj = 0;

    pixel_kernel_seq #(.NPIX(NPIX), .CW(CW), .TO_CYCLES(TO)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .loc_max_clk   (loc_max_clk),
        .adj_max_clk   (adj_max_clk),
        .loc_timer_en  (loc_timer_en),
        .adj_timer_en  (adj_timer_en),
        .pxl_done_i    (pxl_done_i),
        .pxl_start_o   (pxl_start_o),
        .loc_timer_m_o (loc_timer_m_o),
        .adj_timer_m_o (adj_timer_m_o),
        .pxl_idx_o     (pxl_idx_o),
        .busy_o        (busy_o),
        .kernel_done_o (kernel_done_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pixel-FSM stand-in: answers each start pulse with a one-cycle done,
    // sampled resp_delay+1 edges after the start pulse began.
    always @(negedge clk) begin
        if (!resp_en || !reset_n) begin
            resp_cnt  = 0;
            resp_done = 1'b0;
        end else if (pxl_start_o) begin
            resp_cnt  = resp_delay;
            resp_done = 1'b0;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            resp_done = (resp_cnt == 0);
        end else begin
            resp_done = 1'b0;
        end
    end

    // Event monitor: start-pulse times/indices, pulse width, kernel-done count
    always @(negedge clk) begin
        if (reset_n) begin
            if (pxl_start_o) begin
                if (mon_prev_start) mon_wide++;
                else begin
                    start_cyc_q.push_back(cyc);
                    start_idx_q.push_back(int'(pxl_idx_o));
                end
            end
            mon_prev_start = pxl_start_o;
            if (kernel_done_o) mon_done_cnt++;
        end
    end

    // Reference model: advances on each edge from the sampled inputs, then
    // compares every DUT output just after the edge.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_ph = PH_IDLE; m_idx = 0; m_wd = 0; m_err = 0; m_loc = 0; m_adj = 0;
        end else begin
            if (!loc_timer_en)                   m_loc = 0;
            else if (m_loc < int'(loc_max_clk))  m_loc = m_loc + 1;
            if (!adj_timer_en)                   m_adj = 0;
            else if (m_adj < int'(adj_max_clk))  m_adj = m_adj + 1;

            if (abort_i) begin
                m_ph = PH_IDLE;
            end else begin
                case (m_ph)
                    PH_IDLE:  if (start_i) begin m_ph = PH_START; m_idx = 0; m_err = 0; end
                    PH_START: begin m_ph = PH_WAIT; m_wd = 0; end
                    PH_WAIT: begin
                        if (pxl_done_i) begin
                            if (m_idx == NPIX - 1) m_ph = PH_DONE;
                            else begin m_idx = m_idx + 1; m_ph = PH_GAP; end
                        end else if (m_wd == TO) begin
                            m_err = 1; m_ph = PH_IDLE;
                        end else m_wd = m_wd + 1;
                    end
                    PH_GAP:   m_ph = PH_START;
                    default:  m_ph = PH_IDLE;
                endcase
            end
            #1;
            if (reset_n) begin
                chk("model_pxl_start", pxl_start_o, int'(m_ph == PH_START));
                chk("model_kernel_done", kernel_done_o, int'(m_ph == PH_DONE));
                chk("model_busy", busy_o, int'(m_ph != PH_IDLE));
                chk("model_idx", int'(pxl_idx_o), m_idx);
                chk("model_err", err_o, m_err);
                chk("model_loc_m", loc_timer_m_o, int'(loc_timer_en && m_loc == int'(loc_max_clk)));
                chk("model_adj_m", adj_timer_m_o, int'(adj_timer_en && m_adj == int'(adj_max_clk)));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int bound);
        int n = 0;
        while (mon_done_cnt == d0 && n < bound) begin
            step();
            n++;
        end
        chk(name, mon_done_cnt - d0, 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_start"}, pxl_start_o, 0);
        chk({name, "_locm"},  loc_timer_m_o, 0);
        chk({name, "_adjm"},  adj_timer_m_o, 0);
        chk({name, "_idx"},   int'(pxl_idx_o), 0);
        chk({name, "_busy"},  busy_o, 0);
        chk({name, "_done"},  kernel_done_o, 0);
        chk({name, "_err"},   err_o, 0);
    endtask

    initial begin
        int q0, d0, w0, k, n, dcyc;

        // Reset state
        repeat (3) step();
        chk_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Timers: local max 3 for 6 enabled cycles, adjacent max 0 for 2
        loc_max_clk = 10'd3;
        adj_max_clk = 10'd0;
        for (int c = 1; c <= 7; c++) begin
            step();
            loc_timer_en = (c <= 6);
            adj_timer_en = (c <= 2);
            #1;
            chk($sformatf("loc_m_cyc%0d", c), loc_timer_m_o, int'(c >= 4 && c <= 6));
            chk($sformatf("adj_m_cyc%0d", c), adj_timer_m_o, int'(c <= 2));
        end
        step();

        // Basic sweep: 9 pulses, 8 cycles apart, idx 0..8, one done
        q0 = start_cyc_q.size(); w0 = mon_wide; d0 = mon_done_cnt;
        resp_en = 1'b1; resp_delay = 6;
        pulse_start();
        wait_done("sweep_done", d0, 200);
        step();
        chk("sweep_busy_low", busy_o, 0);
        chk("sweep_pulses", start_cyc_q.size() - q0, NPIX);
        chk("sweep_width", mon_wide - w0, 0);
        if (start_cyc_q.size() - q0 == NPIX) begin
            for (int i = 0; i < NPIX; i++)
                chk($sformatf("sweep_idx%0d", i), start_idx_q[q0 + i], i);
            for (int i = 1; i < NPIX; i++)
                chk($sformatf("sweep_gap%0d", i), start_cyc_q[q0 + i] - start_cyc_q[q0 + i - 1], 8);
        end
        repeat (3) step();
        chk("sweep_one_done", mon_done_cnt - d0, 1);

        // Watchdog: no pixel-done ever returned
        resp_en = 1'b0;
        d0 = mon_done_cnt;
        pulse_start();
        k = start_cyc_q[start_cyc_q.size() - 1];
        n = 0;
        while (!err_o && n < 100) begin step(); n++; end
        chk("wd_err_set", err_o, 1);
        dcyc = cyc - k;
        chk("wd_latency", dcyc, TO + 2);
        chk("wd_idle", busy_o, 0);
        chk("wd_no_done", mon_done_cnt - d0, 0);
        resp_en = 1'b1;
        d0 = mon_done_cnt;
        pulse_start();
        chk("wd_err_cleared", err_o, 0);
        wait_done("wd_recover_done", d0, 200);
        step();

        // Pixel-done on the same edge as the timeout: treated as done
        resp_en = 1'b0;
        pulse_start();
        k = start_cyc_q[start_cyc_q.size() - 1];
        n = 0;
        while (cyc < k + TO + 1 && n < 60) begin step(); n++; end
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        chk("tie_err", err_o, 0);
        chk("tie_idx", int'(pxl_idx_o), 1);
        chk("tie_busy", busy_o, 1);
        resp_en = 1'b1;
        d0 = mon_done_cnt;
        wait_done("tie_done", d0, 200);
        step();

        // Abort on the same edge as the last pixel-done
        d0 = mon_done_cnt;
        pulse_start();
        n = 0;
        while (!(pxl_start_o && pxl_idx_o == 4'(NPIX - 1)) && n < 200) begin step(); n++; end
        chk("abort_reach_last", int'(pxl_idx_o), NPIX - 1);
        repeat (6) step();
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort_idle", busy_o, 0);
        chk("abort_idx_held", int'(pxl_idx_o), NPIX - 1);
        repeat (2) step();
        chk("abort_no_done", mon_done_cnt - d0, 0);

        // start_i held through a kernel: restart right after DONE/IDLE
        d0 = mon_done_cnt;
        q0 = start_cyc_q.size();
        start_i = 1'b1;
        n = 0;
        while (mon_done_cnt == d0 && n < 200) begin step(); n++; end
        chk("held_first_done", mon_done_cnt - d0, 1);
        dcyc = cyc;
        n = 0;
        while (start_cyc_q.size() <= q0 + NPIX && n < 10) begin step(); n++; end
        start_i = 1'b0;
        chk("held_restart_seen", start_cyc_q.size() - q0, NPIX + 1);
        if (start_cyc_q.size() > q0 + NPIX) begin
            chk("held_restart_cyc", start_cyc_q[q0 + NPIX] - dcyc, 2);
            chk("held_restart_idx", start_idx_q[q0 + NPIX], 0);
        end
        d0 = mon_done_cnt;
        wait_done("held_second_done", d0, 200);
        step();

        // Pixel-done during START and during GAP is ignored
        d0 = mon_done_cnt;
        pulse_start();
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        chk("ign_start_idx", int'(pxl_idx_o), 0);
        n = 0;
        while (pxl_idx_o != 4'd1 && n < 20) begin step(); n++; end
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        chk("ign_gap_idx", int'(pxl_idx_o), 1);
        chk("ign_gap_restart", pxl_start_o, 1);
        wait_done("ign_done", d0, 200);
        step();

        // Asynchronous reset mid-kernel, then a clean restart
        pulse_start();
        n = 0;
        while (!(pxl_start_o && pxl_idx_o == 4'd4) && n < 100) begin step(); n++; end
        repeat (2) step();
        chk("arst_pre_busy", busy_o, 1);
        resp_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("arst");
        repeat (2) step();
        reset_n = 1'b1;
        resp_en = 1'b1;
        step();
        d0 = mon_done_cnt;
        pulse_start();
        chk("arst_restart_idx", int'(pxl_idx_o), 0);
        chk("arst_restart_pulse", pxl_start_o, 1);
        wait_done("arst_done", d0, 200);

        // Randomized phase, checked by the reference model every cycle
        for (int i = 0; i < 2000; i++) begin
            step();
            start_i    = ($urandom_range(0, 7) == 0);
            abort_i    = ($urandom_range(0, 79) == 0);
            force_done = ($urandom_range(0, 19) == 0);
            loc_timer_en = ($urandom_range(0, 4) != 0);
            adj_timer_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) loc_max_clk = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) adj_max_clk = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) resp_delay = $urandom_range(1, 24);
        end
        start_i = 1'b0; abort_i = 1'b0; force_done = 1'b0;
        loc_timer_en = 1'b0; adj_timer_en = 1'b0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
